input_queue_reader: RTL

- Consumer-side reader for the input pixel index queue.
- After the input layer has streamed all pixels into the queue, it drives the queue's dequeue strobe and captures each active-pixel index.
- Presents each index downstream (hidden-layer accumulation control) on a valid/ready handshake.
- Signals completion when the queue reports empty or MAX_READS indices have been delivered.

---
 rtl/input_queue_reader_pkg.sv | 10 +
 rtl/input_queue_reader.sv | 107 ++++++++++
 2 files changed

// File: rtl/input_queue_reader_pkg.sv
// rtl/input_queue_reader_pkg.sv - shared network constants for the input queue reader
package input_queue_reader_pkg;

    localparam int INPUT_LAYER_NODES = 784;
    localparam int PIXEL_INDEX_WIDTH = 10;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/input_queue_reader.sv
// rtl/input_queue_reader.sv - drains the pixel index queue and hands indices downstream
module input_queue_reader
    import input_queue_reader_pkg::*;
#(
    parameter int MAX_READS   = INPUT_LAYER_NODES,
    parameter int INDEX_WIDTH = PIXEL_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] queue_index,
    input  logic                   queue_empty,
    output logic                   dequeue,
    output logic [INDEX_WIDTH-1:0] index_out,
    output logic                   index_valid,
    input  logic                   index_ready,
    output logic                   busy,
    output logic                   done,
    output logic [INDEX_WIDTH-1:0] read_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DQ_HIGH = 3'd1;
    localparam logic [2:0] S_DQ_LOW  = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [INDEX_WIDTH-1:0] LAST_COUNT = INDEX_WIDTH'(MAX_READS - 1);

    logic [2:0]             state_q, state_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   dequeue_q, dequeue_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   handshake;

    assign handshake = valid_q && index_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            count_q   <= '0;
            valid_q   <= FALSE;
            last_q    <= FALSE;
            dequeue_q <= FALSE;
            busy_q    <= FALSE;
            done_q    <= FALSE;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            dequeue_q <= dequeue_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = queue_empty ? S_DONE : S_DQ_HIGH;
            S_DQ_HIGH: state_d = S_DQ_LOW;
            S_DQ_LOW:  state_d = S_PRESENT;
            S_PRESENT: begin
                if (handshake) begin
                    state_d = (last_q || count_q == LAST_COUNT) ? S_DONE : S_DQ_HIGH;
                end
            end
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Status strobes are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        index_d   = index_q;
        count_d   = count_q;
        valid_d   = valid_q;
        last_d    = last_q;
        dequeue_d = (state_d == S_DQ_HIGH);
        busy_d    = (state_d == S_DQ_HIGH) || (state_d == S_DQ_LOW) || (state_d == S_PRESENT);
        done_d    = (state_d == S_DONE);
        if (state_q == S_DQ_LOW) begin
            index_d = queue_index;
            valid_d = TRUE;
            last_d  = queue_empty;
        end
        if (state_q == S_PRESENT && handshake) begin
            valid_d = FALSE;
            count_d = count_q + 1'b1;
        end
    end

    assign dequeue     = dequeue_q;
    assign index_out   = index_q;
    assign index_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign read_count  = count_q;

endmodule
